// File: rtl/rf_write_queue.sv
// In-order writeback queue in front of the register-file write port.
// Drains one entry per cycle and forwards the youngest pending value on lookup.
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int RW    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [RW-1:0]              enq_reg,
    input  logic [DW-1:0]              enq_data,
    output logic                       enq_ready,
    input  logic                       wr_stall,
    output logic                       write,
    output logic [RW-1:0]              writeregsel,
    output logic [DW-1:0]              writedata,
    input  logic [RW-1:0]              lookup_reg,
    output logic                       lookup_hit,
    output logic [DW-1:0]              lookup_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);

    logic [RW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] count_q,  count_d;

    logic empty, full, enq_acc;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

    assign enq_ready = !full;
    assign enq_acc   = enq_valid && !full;
    assign err       = enq_valid && full;

    // Reset gates the RF port so a draining entry never lands during reset.
    assign write       = !empty && !wr_stall && !rst;
    assign writeregsel = empty ? '0 : reg_q[rd_ptr_q[AW-1:0]];
    assign writedata   = empty ? '0 : data_q[rd_ptr_q[AW-1:0]];
    assign count       = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (write)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (enq_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({enq_acc, write})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_acc) begin
            reg_q[wr_ptr_q[AW-1:0]]  <= enq_reg;
            data_q[wr_ptr_q[AW-1:0]] <= enq_data;
        end
    end

    // Walk oldest to youngest so later matches override; the accepted enq is youngest of all.
    always_comb begin
        logic [AW-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q[AW-1:0] + AW'(k);
            if (((AW+1)'(k) < count_q) && (reg_q[idx] == lookup_reg)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
        if (enq_acc && (enq_reg == lookup_reg)) begin
            lookup_hit  = 1'b1;
            lookup_data = enq_data;
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int RW    = 3;

    logic          clk = 1'b0;
    logic          rst, enq_valid, wr_stall;
    logic [RW-1:0] enq_reg, lookup_reg;
    logic [DW-1:0] enq_data;
    logic          enq_ready, write, lookup_hit, err;
    logic [RW-1:0] writeregsel;
    logic [DW-1:0] writedata, lookup_data;
    logic [2:0]    count;

    rf_write_queue #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_reg(enq_reg), .enq_data(enq_data), .enq_ready(enq_ready),
        .wr_stall(wr_stall), .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .lookup_reg(lookup_reg), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic          s_ready, s_write, s_hit, s_err;
    logic [RW-1:0] s_wsel;
    logic [DW-1:0] s_wdata, s_ldata;
    logic [2:0]    s_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, then advance the model.
    task automatic cyc(input logic r, input logic ev, input logic [RW-1:0] er,
                       input logic [DW-1:0] ed, input logic st, input logic [RW-1:0] lr);
        logic          e_full, e_acc, e_write, e_hit;
        logic [RW-1:0] e_wsel;
        logic [DW-1:0] e_wdata, e_ldata;
        @(negedge clk);
        rst = r; enq_valid = ev; enq_reg = er; enq_data = ed; wr_stall = st; lookup_reg = lr;
        #1;
        e_full  = (mq.size() == DEPTH);
        e_acc   = ev && !e_full;
        e_write = !r && (mq.size() > 0) && !st;
        e_wsel  = (mq.size() > 0) ? mq[0].r : '0;
        e_wdata = (mq.size() > 0) ? mq[0].d : '0;
        e_hit   = 1'b0;
        e_ldata = '0;
        foreach (mq[i]) if (mq[i].r == lr) begin e_hit = 1'b1; e_ldata = mq[i].d; end
        if (e_acc && er == lr) begin e_hit = 1'b1; e_ldata = ed; end
        check("enq_ready",   32'(enq_ready),   32'(!e_full));
        check("err",         32'(err),         32'(ev && e_full));
        check("write",       32'(write),       32'(e_write));
        check("writeregsel", 32'(writeregsel), 32'(e_wsel));
        check("writedata",   32'(writedata),   32'(e_wdata));
        check("lookup_hit",  32'(lookup_hit),  32'(e_hit));
        check("lookup_data", 32'(lookup_data), 32'(e_ldata));
        check("count",       32'(count),       32'(mq.size()));
        s_ready = enq_ready; s_write = write; s_hit = lookup_hit; s_err = err;
        s_wsel = writeregsel; s_wdata = writedata; s_ldata = lookup_data; s_count = count;
        @(posedge clk);
        if (r) mq.delete();
        else begin
            if (e_write) void'(mq.pop_front());
            if (e_acc) mq.push_back('{r: er, d: ed});
        end
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 1'b0, '0, '0, st, '0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_reg = '0; enq_data = '0; wr_stall = 1'b0; lookup_reg = '0;

        // Single enqueue into an empty queue writes on the next cycle.
        do_reset();
        idle(1'b0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_count", 32'(s_count), 32'd0);
        cyc(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd3);
        idle(1'b0);
        check("t1_write", 32'(s_write), 32'd1);
        check("t1_wsel",  32'(s_wsel),  32'd3);
        check("t1_wdata", 32'(s_wdata), 32'h1234);
        idle(1'b0);
        check("t1_write_after", 32'(s_write), 32'd0);
        check("t1_count_after", 32'(s_count), 32'd0);

        // Fill while stalled, overflow attempt, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, RW'(i), 16'hA0 + 16'(i), 1'b1, '0);
        cyc(1'b0, 1'b1, 3'd4, 16'hA4, 1'b1, 3'd4);
        check("t2_ready", 32'(s_ready), 32'd0);
        check("t2_count", 32'(s_count), 32'd4);
        check("t2_err",   32'(s_err),   32'd1);
        check("t2_nohit", 32'(s_hit),   32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check("t2_drain_write", 32'(s_write), 32'd1);
            check("t2_drain_data",  32'(s_wdata), 32'hA0 + 32'(i));
        end
        idle(1'b0);
        check("t2_empty", 32'(s_count), 32'd0);

        // Youngest match wins, including the same-cycle enqueue.
        do_reset();
        cyc(1'b0, 1'b1, 3'd5, 16'h1111, 1'b1, '0);
        cyc(1'b0, 1'b1, 3'd5, 16'h2222, 1'b1, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 3'd5);
        check("t3_hit",   32'(s_hit),   32'd1);
        check("t3_data",  32'(s_ldata), 32'h2222);
        cyc(1'b0, 1'b1, 3'd5, 16'h3333, 1'b1, 3'd5);
        check("t3_fwd",   32'(s_ldata), 32'h3333);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 3'd6);
        check("t3_miss",  32'(s_hit),   32'd0);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Full plus drain rejects the enqueue; then a steady one-per-cycle stream.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, RW'(i), 16'hB0 + 16'(i), 1'b1, '0);
        cyc(1'b0, 1'b1, 3'd7, 16'hBEEF, 1'b0, '0);
        check("t4_err",   32'(s_err),   32'd1);
        check("t4_write", 32'(s_write), 32'd1);
        cyc(1'b0, 1'b1, 3'd6, 16'hC0DE, 1'b0, '0);
        check("t4_count3", 32'(s_count), 32'd3);
        check("t4_ready",  32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, RW'(i), 16'h5000 + 16'(i), 1'b0, RW'(i));
            if (i > 0) check("t4_stream_count", 32'(s_count), 32'd1);
        end
        idle(1'b0);

        // Reset drops queued entries without writing them.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3'd2, 16'hD0 + 16'(i), 1'b1, '0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 3'd2);
        check("t5_rst_write", 32'(s_write), 32'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 3'd2);
        check("t5_write", 32'(s_write), 32'd0);
        check("t5_count", 32'(s_count), 32'd0);
        check("t5_hit",   32'(s_hit),   32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 2) != 0),
                RW'($urandom_range(0, 7)),
                DW'($urandom),
                ($urandom_range(0, 2) == 0),
                RW'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
